branch_resolve_unit: RTL

Parametrised branch resolution unit replacing the single-gate `Branch & Zero` PC-select path. It evaluates six conditional branch types plus unconditional jump on register operands and emits a registered one-cycle `PCSrc` redirect with the target PC. It then holds a multi-cycle `flush` window so the fetch/decode stages can squash wrong-path instructions. It sits between the decode/execute boundary and the PC mux of the pipelined core.

---
 rtl/branch_resolve_unit_pkg.sv | 29 ++
 rtl/branch_resolve_unit_cond_eval.sv | 36 +++
 rtl/branch_resolve_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
// Holds the branch-type codes, FSM states and the flush-counter legality limits.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam int unsigned FLUSH_MAX   = 15;
  localparam int unsigned FLUSH_CNT_W = 4;

  function automatic logic flush_cycles_legal(input int unsigned n);
    return (n >= 1) && (n <= FLUSH_MAX);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator: (br_type, rs_val, rt_val) -> taken.
// Signed two's-complement comparisons over the full WIDTH.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  br_type_e           br_type,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  // Sign bit and zero test are all the signed compares against zero need.
  assign w_rs_neg  = rs_val[WIDTH-1];
  assign w_rs_zero = (rs_val == '0);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLEZ: taken = w_rs_neg | w_rs_zero;
      BR_BGTZ: taken = ~w_rs_neg & ~w_rs_zero;
      BR_BLTZ: taken = w_rs_neg;
      BR_BGEZ: taken = ~w_rs_neg;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: registered one-cycle PCSrc redirect plus a multi-cycle flush window.
// Optional saturating statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] br_target,
  output logic             PCSrc,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic             busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  if (!flush_cycles_legal(FLUSH_CYCLES)) begin : g_bad_flush_cycles
    $error("branch_resolve_unit: FLUSH_CYCLES must be within 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("branch_resolve_unit: CNT_W must be at least 1");
  end

  state_e                 r_state;
  state_e                 w_next_state;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [WIDTH-1:0]       r_redirect_pc;
  br_type_e               w_br_type;
  logic                   w_taken;
  logic                   w_accept;

  assign w_br_type = br_type_e'(br_type);
  // Branches presented while busy are dropped without evaluation.
  assign w_accept  = br_valid && (r_state == ST_IDLE);

  branch_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond_eval (
    .br_type (w_br_type),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept && w_taken) w_next_state = ST_REDIRECT;
      ST_REDIRECT: w_next_state = (r_flush_cnt != '0) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:    if (r_flush_cnt == FLUSH_CNT_W'(1)) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    PCSrc    = 1'b0;
    flush    = 1'b0;
    busy     = 1'b0;
    br_ready = 1'b1;
    case (r_state)
      ST_REDIRECT: begin
        PCSrc    = 1'b1;
        flush    = 1'b1;
        busy     = 1'b1;
        br_ready = 1'b0;
      end
      ST_FLUSH: begin
        flush    = 1'b1;
        busy     = 1'b1;
        br_ready = 1'b0;
      end
      default: ;
    endcase
  end

  // Target latch and flush countdown; REDIRECT holds the count, FLUSH consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt   <= '0;
      r_redirect_pc <= '0;
    end else if (w_accept && w_taken) begin
      r_flush_cnt   <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      r_redirect_pc <= br_target;
    end else if (r_state == ST_FLUSH) begin
      r_flush_cnt   <= r_flush_cnt - FLUSH_CNT_W'(1);
    end
  end

  assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Saturating counters: stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_accept) begin
      if (r_branch_cnt != '1)           r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_taken && r_taken_cnt != '1) r_taken_cnt  <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;
`endif

endmodule
